spi_monitor_bridge: RTL and testbench
=====================================

# spi_monitor_bridge

Parametrised SPI debug-monitor slave that sits between the 68000 bus snoop logic and the external monitor MCU. Fully synchronous to MCLK_IN, it oversamples the SPI pins and returns a bus snapshot (address, data, output signals, status) in every frame. It carries a byte stream in each direction through small FIFOs, CPU→host and host→CPU, and applies host-driven input signals. It replaces the single-byte, SPI-clocked monitor with width-generic fields, queued traffic, sticky overflow flags and abort-safe frames.

## Interface
- ADDR_W, 24, snooped address width
- DATA_W, 16, snooped data width
- OSIG_W, 4, output-signal width (≤8)
- ISIG_W, 4, input-signal width (≤7)
- FIFO_DEPTH, 4, depth of each byte FIFO (power of 2, ≥2)
- MCLK_IN  in  1  system clock; only clock of the block
- RUN_IN  in  1  reset, asynchronous, active-low
- SPICLK_IN / SPISI_IN / SPISS_IN  in  1 each  SPI pins, asynchronous to MCLK_IN; frame active while SPISS_IN high
- ADDR_IN  in  ADDR_W  bus address; DATA_IN  in  DATA_W  bus data; OUTPUT_SIGNAL_IN  in  OSIG_W  CPU-side signals
- UART_SEND_TRIGGER_IN  in  1  one-cycle push strobe; UART_SEND_BYTE_IN  in  8  byte to push
- UART_RECV_ACK_IN  in  1  one-cycle pop strobe for the receive FIFO
- INPUT_SIGNAL  out  ISIG_W  host-driven signals, registered
- SPISO  out  1  serial out, registered
- UART_SEND_BUSY  out  1  transmit FIFO full
- UART_RECV_VALID  out  1  receive FIFO non-empty; UART_RECV_BYTE  out  8  receive FIFO head

## Operation
- SPI mode 1, LSB first. SPICLK/SPISI/SPISS pass through 2-FF synchronisers, then edge detection. Slave drives on rising edge and samples on falling edge.
- TX frame, TX_W = ADDR_W+DATA_W+OSIG_W+4+8 bits, LSB first: {tx_byte, status[3:0], OUTPUT_SIGNAL, DATA, ADDR}. Bits beyond TX_W are 0.
- Status bits:
  - b0: tx_byte valid
  - b1: receive FIFO full
  - b2: tx overflow (sticky)
  - b3: rx overflow (sticky)
- Snapshot: on the first rising edge of a frame (bit count 0), ADDR/DATA/OSIG/status are latched and the transmit FIFO head is peeked (tx_byte = 0 and b0 = 0 if empty). Shifting starts then, so bit 0 is on SPISO after that edge.
- Transmit pop: committed only when TX_W rising edges complete in the same frame. An aborted frame leaves the byte queued for retransmission. Sticky b2/b3 clear on that same completion, unless re-set that cycle.
- RX frame: the first 16 bits sampled, LSB first:
  - bits[ISIG_W-1:0]: input signals
  - bit 7: rx-byte valid
  - bits[15:8]: rx byte
- On the 16th falling edge, INPUT_SIGNAL is loaded. If bit 7 = 1, the byte is pushed to the receive FIFO. If that FIFO is full, the byte is dropped and b3 is set.
- Abort (SPISS_IN low mid-frame): the bit counter goes to 0, partial RX data is discarded, SPISO goes to 0, and INPUT_SIGNAL is unchanged.
- Bit counter saturates at max(TX_W,16) until SPISS_IN falls.
- Transmit push on UART_SEND_TRIGGER_IN:
  - If full, the byte is dropped and b2 is set.
  - A push and a pop in the same cycle when full: the push is accepted.
- Receive pop on UART_RECV_ACK_IN while UART_RECV_VALID; ACK while empty is ignored. Push and pop in the same cycle keep the count.

## Timing
- Reset values: INPUT_SIGNAL 0, SPISO 0, UART_SEND_BUSY 0, UART_RECV_VALID 0, UART_RECV_BYTE 0, both FIFOs empty, sticky flags 0, bit counter 0.
- SPICLK high and low phases each ≥3 MCLK periods. SPISS setup before the first SPICLK rise is ≥3 MCLK periods.
- SPISO updates ≤4 MCLK after a SPICLK pin rising edge (2 sync + 1 detect + 1 register).
- INPUT_SIGNAL and receive push ≤4 MCLK after the 16th falling edge.
- UART_SEND_BUSY / UART_RECV_VALID are registered, valid the cycle after the push/pop edge.
- RUN_IN low mid-frame: everything resets immediately. The frame resumes only after the next SPISS_IN rise.

## Structure
- Package monitor_pkg:
  - status bit indices
  - RX_FRAME_W = 16
  - RX_VALID_BIT = 7
  - function computing TX_W from the parameters
- Sub-module monitor_fifo: 8-bit synchronous FIFO with FIFO_DEPTH, push/pop/full/empty/head, same-cycle push+pop, async active-low reset. Instantiated twice.

## Test plan
- Reset, ADDR=0x123456, DATA=0xBEEF, OSIG=0xA, no push → 56-bit frame reads 0x00_0A_BEEF_123456 LSB first; status 0.
- Push 0x41 then run one full frame → tx_byte 0x41, status b0 = 1; next frame b0 = 0; BUSY never asserted.
- Push 0x55 and abort the frame at bit 30 → next full frame still delivers 0x55; a further frame shows an empty FIFO.
- Push 5 bytes with FIFO_DEPTH = 4 → BUSY high after the 4th push, 5th dropped, b2 = 1 in the next frame and 0 in the one after.
- Host sends RX 0x5A_85 → INPUT_SIGNAL = 0x5, RECV_VALID = 1, RECV_BYTE = 0x5A; ACK → VALID = 0.
- Host sends 5 valid RX bytes with no ACK → status b1 = 1, 5th byte dropped, b3 = 1; a frame cut at bit 10 leaves INPUT_SIGNAL unchanged.

Source files
------------

// File: rtl/monitor_pkg.sv
// monitor_pkg
// Shared constants for the SPI debug-monitor bridge:
//   - status bit positions inside the transmitted frame
//   - receive frame geometry (RX_FRAME_W, RX_VALID_BIT)
//   - tx_width(): length of the transmitted snapshot frame
package monitor_pkg;

    localparam int STAT_TX_VALID = 0;  // tx_byte field carries a real byte
    localparam int STAT_RX_FULL  = 1;  // receive FIFO is full
    localparam int STAT_TX_OVF   = 2;  // sticky: a CPU push was dropped
    localparam int STAT_RX_OVF   = 3;  // sticky: a host byte was dropped
    localparam int STATUS_W      = 4;
    localparam int TX_BYTE_W     = 8;

    localparam int RX_FRAME_W    = 16;
    localparam int RX_VALID_BIT  = 7;

    function automatic int tx_width(input int addr_w, input int data_w, input int osig_w);
        return addr_w + data_w + osig_w + STATUS_W + TX_BYTE_W;
    endfunction

    function automatic int max_int(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/spi_monitor_bridge_if.sv
// spi_monitor_bridge_if
// CPU-side byte queue signals of the monitor bridge.
//   UART_SEND_TRIGGER_IN / UART_SEND_BYTE_IN : one-cycle push into the transmit FIFO
//   UART_SEND_BUSY                          : transmit FIFO full
//   UART_RECV_ACK_IN                        : one-cycle pop of the receive FIFO
//   UART_RECV_VALID / UART_RECV_BYTE        : receive FIFO non-empty / head byte
// Handshake: a push is a single-cycle strobe; when BUSY is high the push is
// dropped (and flagged) unless a pop frees a slot in the same cycle.  A byte
// transfers to the CPU in any cycle where RECV_VALID and RECV_ACK are both
// high; ACK while RECV_VALID is low has no effect.
interface spi_monitor_bridge_if;

    logic       UART_SEND_TRIGGER_IN;
    logic [7:0] UART_SEND_BYTE_IN;
    logic       UART_SEND_BUSY;
    logic       UART_RECV_ACK_IN;
    logic       UART_RECV_VALID;
    logic [7:0] UART_RECV_BYTE;

    modport master (
        output UART_SEND_TRIGGER_IN, UART_SEND_BYTE_IN, UART_RECV_ACK_IN,
        input  UART_SEND_BUSY, UART_RECV_VALID, UART_RECV_BYTE
    );

    modport slave (
        input  UART_SEND_TRIGGER_IN, UART_SEND_BYTE_IN, UART_RECV_ACK_IN,
        output UART_SEND_BUSY, UART_RECV_VALID, UART_RECV_BYTE
    );

endinterface

// File: rtl/monitor_fifo.sv
// monitor_fifo
// 8-bit synchronous FIFO, FIFO_DEPTH entries (power of two, >= 2).
//   clk, rst_n   : clock, asynchronous active-low reset
//   push, push_data : write strobe and byte; accepted when not full, or when
//                     a pop happens in the same cycle
//   pop          : read strobe; ignored while empty
//   full, empty  : registered status flags
//   head         : oldest entry (0 after reset)
module monitor_fifo #(
    parameter int FIFO_DEPTH = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       push,
    input  logic [7:0] push_data,
    input  logic       pop,
    output logic       full,
    output logic       empty,
    output logic [7:0] head
);

    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam logic [PTR_W:0] DEPTH_C = (PTR_W + 1)'(FIFO_DEPTH);

    logic [7:0]       mem [FIFO_DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [PTR_W:0]   count;
    logic [PTR_W:0]   count_nxt;
    logic             do_push;
    logic             do_pop;

    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);
    assign head    = mem[rd_ptr];

    always_comb begin
        count_nxt = count;
        if (do_push && !do_pop) begin
            count_nxt = count + (PTR_W + 1)'(1);
        end else if (!do_push && do_pop) begin
            count_nxt = count - (PTR_W + 1)'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                mem[i] <= 8'h00;
            end
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            full   <= 1'b0;
            empty  <= 1'b1;
        end else begin
            if (do_push) begin
                mem[wr_ptr] <= push_data;
                wr_ptr      <= wr_ptr + PTR_W'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            count <= count_nxt;
            full  <= (count_nxt == DEPTH_C);
            empty <= (count_nxt == '0);
        end
    end

endmodule

// File: rtl/spi_monitor_bridge.sv
// spi_monitor_bridge
// SPI mode-1, LSB-first debug-monitor slave clocked entirely by MCLK_IN.
// Every frame returns {tx_byte, status, OUTPUT_SIGNAL_IN, DATA_IN, ADDR_IN}
// and accepts a 16-bit host word {rx_byte, rx_valid, -, INPUT_SIGNAL}.
//   MCLK_IN, RUN_IN               : clock, asynchronous active-low reset
//   SPICLK_IN/SPISI_IN/SPISS_IN   : asynchronous SPI pins (frame while SPISS_IN high)
//   ADDR_IN, DATA_IN, OUTPUT_SIGNAL_IN : bus snapshot sources
//   uart                          : CPU-side byte queues (transmit and receive FIFOs)
//   INPUT_SIGNAL                  : host-driven signals, registered
//   SPISO                         : serial out, registered
module spi_monitor_bridge
    import monitor_pkg::*;
#(
    parameter int ADDR_W     = 24,
    parameter int DATA_W     = 16,
    parameter int OSIG_W     = 4,
    parameter int ISIG_W     = 4,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                 MCLK_IN,
    input  logic                 RUN_IN,
    input  logic                 SPICLK_IN,
    input  logic                 SPISI_IN,
    input  logic                 SPISS_IN,
    input  logic [ADDR_W-1:0]    ADDR_IN,
    input  logic [DATA_W-1:0]    DATA_IN,
    input  logic [OSIG_W-1:0]    OUTPUT_SIGNAL_IN,
    spi_monitor_bridge_if.slave  uart,
    output logic [ISIG_W-1:0]    INPUT_SIGNAL,
    output logic                 SPISO
);

    localparam int TX_W    = tx_width(ADDR_W, DATA_W, OSIG_W);
    localparam int CNT_MAX = max_int(TX_W, RX_FRAME_W);
    localparam int CNT_W   = $clog2(CNT_MAX + 1);
    localparam logic [CNT_W-1:0] CNT_TOP = CNT_W'(CNT_MAX);
    localparam logic [CNT_W-1:0] TX_LAST = CNT_W'(TX_W - 1);
    localparam logic [CNT_W-1:0] RX_LAST = CNT_W'(RX_FRAME_W);

    // Synchronisers.  SPISS resets to "high" so a frame already in progress
    // when RUN_IN releases is ignored until SPISS is seen low again.
    logic [1:0] sclk_sync, si_sync, ss_sync;
    logic       sclk_q;
    logic       armed;
    logic       sclk_rise, sclk_fall, si_s, frame_on;

    logic [CNT_W-1:0]      bit_cnt;
    logic [TX_W-1:0]       tx_sh;
    logic [TX_W-1:0]       tx_frame;
    logic [RX_FRAME_W-1:0] rx_sh;
    logic [RX_FRAME_W-1:0] rx_word;
    logic [STATUS_W-1:0]   status;
    logic                  snap_valid, snap_tx_ovf, snap_rx_ovf;
    logic                  tx_ovf, rx_ovf;

    logic       tx_full, tx_empty, rx_full, rx_empty;
    logic [7:0] tx_head, rx_head, tx_byte;
    logic       tx_done, rx_done, tx_pop, rx_push, rx_pop;
    logic       tx_ovf_set, rx_ovf_set;

    assign sclk_rise = sclk_sync[1] & ~sclk_q;
    assign sclk_fall = ~sclk_sync[1] & sclk_q;
    assign si_s      = si_sync[1];
    assign frame_on  = ss_sync[1] & armed;

    assign tx_byte = tx_empty ? 8'h00 : tx_head;

    always_comb begin
        status                = '0;
        status[STAT_TX_VALID] = ~tx_empty;
        status[STAT_RX_FULL]  = rx_full;
        status[STAT_TX_OVF]   = tx_ovf;
        status[STAT_RX_OVF]   = rx_ovf;
    end

    assign tx_frame = {tx_byte, status, OUTPUT_SIGNAL_IN, DATA_IN, ADDR_IN};
    assign rx_word  = {si_s, rx_sh[RX_FRAME_W-1:1]};

    // The snapshot byte is popped only once the host has clocked the whole frame.
    assign tx_done = frame_on & sclk_rise & (bit_cnt == TX_LAST);
    assign tx_pop  = tx_done & snap_valid;
    assign rx_done = frame_on & sclk_fall & (bit_cnt == RX_LAST);
    assign rx_push = rx_done & rx_word[RX_VALID_BIT];
    assign rx_pop  = uart.UART_RECV_ACK_IN & ~rx_empty;

    assign tx_ovf_set = uart.UART_SEND_TRIGGER_IN & tx_full & ~tx_pop;
    assign rx_ovf_set = rx_push & rx_full & ~rx_pop;

    assign uart.UART_SEND_BUSY  = tx_full;
    assign uart.UART_RECV_VALID = ~rx_empty;
    assign uart.UART_RECV_BYTE  = rx_head;

    always_ff @(posedge MCLK_IN or negedge RUN_IN) begin
        if (!RUN_IN) begin
            sclk_sync <= 2'b00;
            si_sync   <= 2'b00;
            ss_sync   <= 2'b11;
            sclk_q    <= 1'b0;
            armed     <= 1'b0;
        end else begin
            sclk_sync <= {sclk_sync[0], SPICLK_IN};
            si_sync   <= {si_sync[0], SPISI_IN};
            ss_sync   <= {ss_sync[0], SPISS_IN};
            sclk_q    <= sclk_sync[1];
            if (!ss_sync[1]) begin
                armed <= 1'b1;
            end
        end
    end

    always_ff @(posedge MCLK_IN or negedge RUN_IN) begin
        if (!RUN_IN) begin
            bit_cnt      <= '0;
            tx_sh        <= '0;
            rx_sh        <= '0;
            SPISO        <= 1'b0;
            INPUT_SIGNAL <= '0;
            snap_valid   <= 1'b0;
            snap_tx_ovf  <= 1'b0;
            snap_rx_ovf  <= 1'b0;
        end else if (!frame_on) begin
            bit_cnt <= '0;
            SPISO   <= 1'b0;
        end else begin
            if (sclk_rise) begin
                if (bit_cnt != CNT_TOP) begin
                    bit_cnt <= bit_cnt + CNT_W'(1);
                end
                if (bit_cnt == '0) begin
                    SPISO       <= tx_frame[0];
                    tx_sh       <= tx_frame >> 1;
                    snap_valid  <= ~tx_empty;
                    snap_tx_ovf <= tx_ovf;
                    snap_rx_ovf <= rx_ovf;
                end else if (bit_cnt <= TX_LAST) begin
                    SPISO <= tx_sh[0];
                    tx_sh <= tx_sh >> 1;
                end else begin
                    SPISO <= 1'b0;
                end
            end
            if (sclk_fall && (bit_cnt != '0) && (bit_cnt <= RX_LAST)) begin
                rx_sh <= rx_word;
            end
            if (rx_done) begin
                INPUT_SIGNAL <= rx_word[ISIG_W-1:0];
            end
        end
    end

    // A sticky flag is cleared only by a completed frame that actually
    // carried it to the host; a new overflow in that cycle wins.
    always_ff @(posedge MCLK_IN or negedge RUN_IN) begin
        if (!RUN_IN) begin
            tx_ovf <= 1'b0;
            rx_ovf <= 1'b0;
        end else begin
            tx_ovf <= tx_ovf_set | (tx_ovf & ~(tx_done & snap_tx_ovf));
            rx_ovf <= rx_ovf_set | (rx_ovf & ~(tx_done & snap_rx_ovf));
        end
    end

    monitor_fifo #(.FIFO_DEPTH(FIFO_DEPTH)) u_tx_fifo (
        .clk       (MCLK_IN),
        .rst_n     (RUN_IN),
        .push      (uart.UART_SEND_TRIGGER_IN),
        .push_data (uart.UART_SEND_BYTE_IN),
        .pop       (tx_pop),
        .full      (tx_full),
        .empty     (tx_empty),
        .head      (tx_head)
    );

    monitor_fifo #(.FIFO_DEPTH(FIFO_DEPTH)) u_rx_fifo (
        .clk       (MCLK_IN),
        .rst_n     (RUN_IN),
        .push      (rx_push),
        .push_data (rx_word[15:8]),
        .pop       (uart.UART_RECV_ACK_IN),
        .full      (rx_full),
        .empty     (rx_empty),
        .head      (rx_head)
    );

endmodule

// File: tb/tb_spi_monitor_bridge.sv
// tb_spi_monitor_bridge
// Drives SPI frames and CPU queue traffic; every full frame's expected
// snapshot is queued from a queue-based reference model and compared by a
// monitor that collects SPISO independently.
module tb_spi_monitor_bridge;
    import monitor_pkg::*;

    localparam int ADDR_W     = 24;
    localparam int DATA_W     = 16;
    localparam int OSIG_W     = 4;
    localparam int ISIG_W     = 4;
    localparam int FIFO_DEPTH = 4;
    localparam int TX_W       = tx_width(ADDR_W, DATA_W, OSIG_W);
    localparam int HALF       = 4;

    // ---------------- clock / reset / DUT ----------------
    logic              mclk = 1'b0;
    logic              run_n = 1'b0;
    logic              sclk = 1'b0;
    logic              si = 1'b0;
    logic              ss = 1'b0;
    logic [ADDR_W-1:0] addr = '0;
    logic [DATA_W-1:0] data = '0;
    logic [OSIG_W-1:0] osig = '0;
    logic [ISIG_W-1:0] input_signal;
    logic              spiso;

    spi_monitor_bridge_if uart();

    spi_monitor_bridge #(
        .ADDR_W(ADDR_W), .DATA_W(DATA_W), .OSIG_W(OSIG_W),
        .ISIG_W(ISIG_W), .FIFO_DEPTH(FIFO_DEPTH)
    ) dut (
        .MCLK_IN          (mclk),
        .RUN_IN           (run_n),
        .SPICLK_IN        (sclk),
        .SPISI_IN         (si),
        .SPISS_IN         (ss),
        .ADDR_IN          (addr),
        .DATA_IN          (data),
        .OUTPUT_SIGNAL_IN (osig),
        .uart             (uart),
        .INPUT_SIGNAL     (input_signal),
        .SPISO            (spiso)
    );

    always #5 mclk = ~mclk;

    // ---------------- scoreboard state ----------------
    int              n_cmp = 0;
    int              n_err = 0;
    logic [TX_W-1:0] exp_q[$];

    // reference model
    logic [7:0]        m_tx[$];
    logic [7:0]        m_rx[$];
    bit                m_tx_ovf = 1'b0;
    bit                m_rx_ovf = 1'b0;
    logic [ISIG_W-1:0] m_isig = '0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [63:0] model_frame();
        logic [7:0]  b;
        logic [3:0]  st;
        logic [63:0] e;
        b  = (m_tx.size() > 0) ? m_tx[0] : 8'h00;
        st = {m_rx_ovf, m_tx_ovf, (m_rx.size() == FIFO_DEPTH), (m_tx.size() > 0)};
        e  = 64'(addr)
           | (64'(data) << ADDR_W)
           | (64'(osig) << (ADDR_W + DATA_W))
           | (64'(st)   << (ADDR_W + DATA_W + OSIG_W))
           | (64'(b)    << (ADDR_W + DATA_W + OSIG_W + 4));
        return e;
    endfunction

    // ---------------- driver tasks ----------------
    task automatic spi_frame(input int nbits, input logic [15:0] rx);
        logic [63:0] e;
        bit had_tx, snap_txo, snap_rxo;
        had_tx   = (m_tx.size() > 0);
        snap_txo = m_tx_ovf;
        snap_rxo = m_rx_ovf;
        if (nbits >= TX_W) begin
            e = model_frame();
            exp_q.push_back(e[TX_W-1:0]);
        end
        @(negedge mclk);
        ss = 1'b1;
        repeat (HALF) @(negedge mclk);
        for (int i = 0; i < nbits; i++) begin
            sclk = 1'b1;
            si   = (i < 16) ? rx[i] : 1'b0;
            repeat (HALF) @(negedge mclk);
            sclk = 1'b0;
            repeat (HALF) @(negedge mclk);
        end
        ss = 1'b0;
        si = 1'b0;
        repeat (HALF) @(negedge mclk);
        if (nbits >= RX_FRAME_W) begin
            m_isig = rx[ISIG_W-1:0];
            if (rx[RX_VALID_BIT]) begin
                if (m_rx.size() == FIFO_DEPTH) m_rx_ovf = 1'b1;
                else m_rx.push_back(rx[15:8]);
            end
        end
        if (nbits >= TX_W) begin
            if (had_tx) void'(m_tx.pop_front());
            if (snap_txo) m_tx_ovf = 1'b0;
            if (snap_rxo) m_rx_ovf = 1'b0;
        end
    endtask

    task automatic uart_push(input logic [7:0] b);
        @(negedge mclk);
        uart.UART_SEND_TRIGGER_IN = 1'b1;
        uart.UART_SEND_BYTE_IN    = b;
        @(negedge mclk);
        uart.UART_SEND_TRIGGER_IN = 1'b0;
        if (m_tx.size() == FIFO_DEPTH) m_tx_ovf = 1'b1;
        else m_tx.push_back(b);
    endtask

    task automatic uart_ack();
        if (m_rx.size() > 0) check("recv_byte_at_ack", 64'(uart.UART_RECV_BYTE), 64'(m_rx[0]));
        @(negedge mclk);
        uart.UART_RECV_ACK_IN = 1'b1;
        @(negedge mclk);
        uart.UART_RECV_ACK_IN = 1'b0;
        if (m_rx.size() > 0) void'(m_rx.pop_front());
    endtask

    task automatic check_outputs(input string tag);
        check({tag, ".input_signal"}, 64'(input_signal), 64'(m_isig));
        check({tag, ".busy"}, 64'(uart.UART_SEND_BUSY), 64'(m_tx.size() == FIFO_DEPTH));
        check({tag, ".recv_valid"}, 64'(uart.UART_RECV_VALID), 64'(m_rx.size() > 0));
        if (m_rx.size() > 0) check({tag, ".recv_byte"}, 64'(uart.UART_RECV_BYTE), 64'(m_rx[0]));
    endtask

    // ---------------- monitor: collects SPISO per frame ----------------
    initial begin : monitor
        logic [TX_W-1:0] cap;
        int nb;
        forever begin
            @(posedge ss);
            cap = '0;
            nb  = 0;
            while (ss) begin
                @(negedge sclk or negedge ss);
                if (ss) begin
                    if (nb < TX_W) cap[nb] = spiso;
                    nb++;
                end
            end
            if (nb >= TX_W) begin
                if (exp_q.size() == 0) begin
                    n_cmp++;
                    n_err++;
                    $display("FAIL frame: got %0h expected nothing queued", cap);
                end else begin
                    check("frame", 64'(cap), 64'(exp_q.pop_front()));
                end
            end
        end
    end

    initial begin : watchdog
        #2000000;
        $display("FAIL watchdog: time limit reached, got no finish expected finish");
        $fatal(1, "timeout");
    end

    // ---------------- stimulus ----------------
    initial begin : stimulus
        int np, na, nb;
        uart.UART_SEND_TRIGGER_IN = 1'b0;
        uart.UART_SEND_BYTE_IN    = 8'h00;
        uart.UART_RECV_ACK_IN     = 1'b0;

        run_n = 1'b0;
        repeat (4) @(negedge mclk);
        check("reset.spiso", 64'(spiso), 64'd0);
        check("reset.input_signal", 64'(input_signal), 64'd0);
        check("reset.busy", 64'(uart.UART_SEND_BUSY), 64'd0);
        check("reset.recv_valid", 64'(uart.UART_RECV_VALID), 64'd0);
        check("reset.recv_byte", 64'(uart.UART_RECV_BYTE), 64'd0);
        run_n = 1'b1;
        repeat (4) @(negedge mclk);

        // plain snapshot, empty queues
        addr = 24'h123456;
        data = 16'hBEEF;
        osig = 4'hA;
        spi_frame(TX_W, 16'h0000);
        check_outputs("snap");

        // one queued byte, delivered once
        uart_push(8'h41);
        check_outputs("push41");
        spi_frame(TX_W, 16'h0000);
        spi_frame(TX_W, 16'h0000);
        check_outputs("after41");

        // aborted frame keeps the byte queued
        uart_push(8'h55);
        spi_frame(30, 16'h0003);
        check_outputs("abort30");
        spi_frame(TX_W, 16'h0003);
        spi_frame(TX_W, 16'h0003);

        // transmit overflow
        for (int k = 0; k < 5; k++) begin
            uart_push(8'(8'h10 + k));
            check_outputs("txfill");
        end
        for (int k = 0; k < 5; k++) spi_frame(TX_W, 16'h0000);
        check_outputs("txdrain");

        // host byte reception
        spi_frame(TX_W, 16'h5A85);
        check_outputs("rx5a");
        uart_ack();
        check_outputs("rx5a_ack");

        // receive overflow, then a short frame
        for (int k = 0; k < 5; k++) spi_frame(TX_W, {8'(8'hC0 + k), 8'h80 | 8'(k)});
        check_outputs("rxfill");
        spi_frame(TX_W, 16'h0002);
        spi_frame(TX_W, 16'h0002);
        spi_frame(10, 16'h00FF);
        check_outputs("cut10");
        for (int k = 0; k < 4; k++) uart_ack();
        check_outputs("rxdrain");

        // randomized traffic
        for (int it = 0; it < 30; it++) begin
            addr = ADDR_W'($urandom);
            data = DATA_W'($urandom);
            osig = OSIG_W'($urandom);
            np = $urandom_range(0, 3);
            for (int k = 0; k < np; k++) uart_push(8'($urandom));
            na = $urandom_range(0, 2);
            for (int k = 0; k < na; k++) uart_ack();
            nb = ($urandom_range(0, 3) == 0) ? $urandom_range(1, TX_W - 1) : TX_W;
            spi_frame(nb, 16'($urandom));
            check_outputs("rand");
        end

        check("frames_pending", 64'(exp_q.size()), 64'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
